pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register for the RV64I/Zba core. It is the generalised successor to the fixed D→E register and is intended for all stage boundaries (F/D, D/E, E/M, M/W).
- Adds a valid/ready handshake, stall by back-pressure, flush with bubble insertion, and an optional 2-entry skid buffer so that ready does not have to be routed combinationally across the stage.
- The data payload and the control payload are separate fields. Control is forced to a safe bubble code whenever the stage holds no valid instruction.

---
 rtl/pipe_pkg.sv | 56 +++++
 rtl/pipe_skid_ctrl.sv | 94 +++++++++
 rtl/pipe_stage_reg.sv | 92 +++++++++
 tb/tb_pipe_stage_reg.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and payload layout constants for the inter-stage pipeline registers
// of the RV64I/Zba core.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    BOTH  = 2'd2
  } pipe_state_t;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned OCC_W  = 2;
  localparam int unsigned CTRL_W_RV64 = 16;

  // All-zero control word: no register write, no memory write, no branch/jump.
  localparam logic [CTRL_W_RV64-1:0] CTRL_NOP_RV64 = '0;

  // D/E data payload: {ImmExt, PC, RD2, RD1}
  localparam int unsigned DE_RD1_LSB = 0;
  localparam int unsigned DE_RD2_LSB = 64;
  localparam int unsigned DE_PC_LSB  = 128;
  localparam int unsigned DE_IMM_LSB = 192;
  localparam int unsigned DE_DATA_W  = 256;

  // E/M data payload: {PCPlus4, WriteData, ALUResult}
  localparam int unsigned EM_ALU_LSB  = 0;
  localparam int unsigned EM_WD_LSB   = 64;
  localparam int unsigned EM_PCP4_LSB = 128;
  localparam int unsigned EM_DATA_W   = 192;

  // Control payload fields
  localparam int unsigned CTRL_REGWRITE_BIT = 0;
  localparam int unsigned CTRL_RESSRC_LSB   = 1;   // 2 bits
  localparam int unsigned CTRL_MEMWRITE_BIT = 3;
  localparam int unsigned CTRL_ALUCTL_LSB   = 4;   // 4 bits
  localparam int unsigned CTRL_ALUSRC_BIT   = 8;
  localparam int unsigned CTRL_BRANCH_BIT   = 9;
  localparam int unsigned CTRL_JUMP_BIT     = 10;
  localparam int unsigned CTRL_RD_LSB       = 11;  // 5 bits

  function automatic logic [OCC_W-1:0] state_occ(input pipe_state_t s);
    case (s)
      MAIN:    state_occ = OCC_W'(1);
      BOTH:    state_occ = OCC_W'(2);
      default: state_occ = OCC_W'(0);
    endcase
  endfunction

  function automatic logic [DE_DATA_W-1:0] pack_de(input logic [XLEN-1:0] rd1,
                                                   input logic [XLEN-1:0] rd2,
                                                   input logic [XLEN-1:0] pc,
                                                   input logic [XLEN-1:0] imm);
    pack_de = {imm, pc, rd2, rd1};
  endfunction

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Occupancy FSM and valid/ready/load-enable generation for a pipeline stage;
// independent of payload width.
module pipe_skid_ctrl
  import pipe_pkg::*;
#(
  parameter bit SKID = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             flush,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic             load_main,
  output logic             main_from_skid,
  output logic [OCC_W-1:0] occupancy
);

  pipe_state_t      state_q, state_d;
  logic             out_valid_q;
  logic [OCC_W-1:0] occ_q;
  logic             in_xfer, out_xfer;

  assign out_valid = out_valid_q;
  assign occupancy = occ_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid_q & out_ready;

  // Next state and load enables; flush wins and suppresses all loads.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d   = MAIN;
            load_main = 1'b1;
          end
        end
        MAIN: begin
          if (in_xfer && !out_xfer) begin
            state_d = BOTH;
          end else if (in_xfer) begin
            load_main = 1'b1;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        BOTH: begin
          if (out_xfer) begin
            state_d        = MAIN;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != EMPTY);
      occ_q       <= state_occ(state_d);
    end
  end

  generate
    if (SKID) begin : g_skid
      // Registered ready: no combinational path from out_ready.
      logic in_ready_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_d != BOTH);
        end
      end
      assign in_ready = in_ready_q;
    end else begin : g_single
      assign in_ready = !out_valid_q | out_ready;
    end
  endgenerate

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake, flush,
// optional 2-entry skid buffer and bubble-gated control output.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W      = 256,
  parameter int unsigned        CTRL_W      = 16,
  parameter bit                 SKID        = 1'b1,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OCC_W-1:0]  occupancy
);

  logic              load_main, main_from_skid;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl;

  pipe_skid_ctrl #(
    .SKID (SKID)
  ) u_ctrl (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .flush          (flush),
    .out_ready      (out_ready),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .load_main      (load_main),
    .main_from_skid (main_from_skid),
    .occupancy      (occupancy)
  );

  // Head entry: refilled from skid (older) or directly from the input.
  always_comb begin
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    if (main_from_skid) begin
      main_data_d = skid_data;
      main_ctrl_d = skid_ctrl;
    end else if (load_main) begin
      main_data_d = in_data;
      main_ctrl_d = in_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
    end else begin
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
    end
  end

  generate
    if (SKID) begin : g_skid
      // Skid captures every accepted input; it only matters when main stays occupied.
      logic [DATA_W-1:0] skid_data_q;
      logic [CTRL_W-1:0] skid_ctrl_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          skid_data_q <= '0;
          skid_ctrl_q <= '0;
        end else if (in_valid && in_ready && !flush) begin
          skid_data_q <= in_data;
          skid_ctrl_q <= in_ctrl;
        end
      end
      assign skid_data = skid_data_q;
      assign skid_ctrl = skid_ctrl_q;
    end else begin : g_single
      assign skid_data = '0;
      assign skid_ctrl = '0;
    end
  endgenerate

  assign out_data = main_data_q;
  assign out_ctrl = out_valid ? main_ctrl_q : CTRL_BUBBLE;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a SKID=1 instance driven through directed
// and random traffic, plus a SKID=0 instance exercised with directed steps.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  typedef struct packed {
    logic [255:0] d;
    logic [15:0]  c;
  } ent_t;

  logic clk, rst_n;

  logic         in_valid, in_ready, flush, out_valid, out_ready;
  logic [255:0] in_data, out_data;
  logic [15:0]  in_ctrl, out_ctrl;
  logic [1:0]   occupancy;

  logic        in_valid0, in_ready0, flush0, out_valid0, out_ready0;
  logic [31:0] in_data0, out_data0;
  logic [7:0]  in_ctrl0, out_ctrl0;
  logic [1:0]  occupancy0;

  int   tests = 0;
  int   fails = 0;
  ent_t sb[$];

  pipe_stage_reg #(
    .DATA_W(256), .CTRL_W(16), .SKID(1'b1), .CTRL_BUBBLE(CTRL_NOP_RV64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  pipe_stage_reg #(
    .DATA_W(32), .CTRL_W(8), .SKID(1'b0), .CTRL_BUBBLE(8'hA5)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .in_ctrl(in_ctrl0), .flush(flush0), .out_valid(out_valid0),
    .out_ready(out_ready0), .out_data(out_data0), .out_ctrl(out_ctrl0),
    .occupancy(occupancy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One SKID=1 cycle: drive, check against scoreboard, then advance the model.
  task automatic cycle(input logic iv, input logic [7:0] tag, input logic orr, input logic fl);
    logic [255:0] d;
    logic [15:0]  c;
    logic         in_x, out_x;
    ent_t         e;
    d = {32{tag}};
    c = {~tag, tag};
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = orr;
    flush     = fl;
    #1;
    chk("occupancy", 256'(occupancy), 256'(sb.size()));
    chk("in_ready", 256'(in_ready), 256'(sb.size() < 2));
    chk("out_valid", 256'(out_valid), 256'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("out_data", out_data, sb[0].d);
      chk("out_ctrl", 256'(out_ctrl), 256'(sb[0].c));
    end else begin
      chk("out_ctrl_bubble", 256'(out_ctrl), 256'(CTRL_NOP_RV64));
    end
    in_x  = iv && (sb.size() < 2);
    out_x = orr && (sb.size() != 0);
    if (out_x) void'(sb.pop_front());
    if (fl) begin
      sb.delete();
    end else if (in_x) begin
      e.d = d;
      e.c = c;
      sb.push_back(e);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1; in_data = {32{8'hAA}}; in_ctrl = 16'hFFFF;
    out_ready = 1'b0; flush = 1'b0;
    in_valid0 = 1'b0; in_data0 = '0; in_ctrl0 = '0; out_ready0 = 1'b0; flush0 = 1'b0;

    // Reset held with traffic presented
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_ctrl", 256'(out_ctrl), 256'(CTRL_NOP_RV64));
    chk("rst_occupancy", 256'(occupancy), 256'(0));
    chk("rst_out_data", out_data, 256'(0));
    chk("rst_in_ready0", 256'(in_ready0), 256'(1));
    chk("rst_out_ctrl0", 256'(out_ctrl0), 256'(8'hA5));
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", 256'(in_ready), 256'(1));

    // Streaming 1..8
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Back-pressure: fill both entries, hold, offer a refused item, then drain
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h99, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush in BOTH with incoming 0x33 and no drain
    cycle(1'b1, 8'h31, 1'b0, 1'b0);
    cycle(1'b1, 8'h32, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush coincident with out transfer of 0x44
    cycle(1'b1, 8'h44, 1'b0, 1'b0);
    cycle(1'b1, 8'h45, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 80; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0));
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset asserted mid-transfer
    cycle(1'b1, 8'h66, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {32{8'h77}};
    rst_n    = 1'b0;
    #1;
    chk("midrst_out_valid", 256'(out_valid), 256'(0));
    chk("midrst_occupancy", 256'(occupancy), 256'(0));
    chk("midrst_out_data", out_data, 256'(0));
    chk("midrst_out_ctrl", 256'(out_ctrl), 256'(CTRL_NOP_RV64));
    chk("midrst_in_ready", 256'(in_ready), 256'(1));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h88, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // SKID=0 instance: combinational ready
    @(negedge clk);
    in_valid0 = 1'b1; in_data0 = 32'h50; in_ctrl0 = 8'h01; out_ready0 = 1'b0;
    #1;
    chk("s0_in_ready_empty", 256'(in_ready0), 256'(1));
    @(negedge clk);
    in_valid0 = 1'b1; in_data0 = 32'h55; in_ctrl0 = 8'h02;
    #1;
    chk("s0_out_valid", 256'(out_valid0), 256'(1));
    chk("s0_out_data_50", 256'(out_data0), 256'(32'h50));
    chk("s0_out_ctrl_01", 256'(out_ctrl0), 256'(8'h01));
    chk("s0_occupancy1", 256'(occupancy0), 256'(1));
    chk("s0_in_ready_stall", 256'(in_ready0), 256'(0));
    out_ready0 = 1'b1;
    #1;
    chk("s0_in_ready_comb", 256'(in_ready0), 256'(1));
    @(negedge clk);
    in_valid0 = 1'b0; out_ready0 = 1'b0;
    #1;
    chk("s0_out_data_55", 256'(out_data0), 256'(32'h55));
    chk("s0_out_ctrl_02", 256'(out_ctrl0), 256'(8'h02));
    chk("s0_out_valid_55", 256'(out_valid0), 256'(1));
    out_ready0 = 1'b1;
    @(negedge clk);
    out_ready0 = 1'b0;
    #1;
    chk("s0_empty_valid", 256'(out_valid0), 256'(0));
    chk("s0_empty_ctrl", 256'(out_ctrl0), 256'(8'hA5));
    chk("s0_empty_occ", 256'(occupancy0), 256'(0));

    // SKID=0 flush with an incoming item
    in_valid0 = 1'b1; in_data0 = 32'h77; in_ctrl0 = 8'h03;
    @(negedge clk);
    in_data0 = 32'h78; flush0 = 1'b1;
    #1;
    chk("s0_pre_flush_valid", 256'(out_valid0), 256'(1));
    @(negedge clk);
    in_valid0 = 1'b0; flush0 = 1'b0;
    #1;
    chk("s0_flush_valid", 256'(out_valid0), 256'(0));
    chk("s0_flush_ctrl", 256'(out_ctrl0), 256'(8'hA5));
    chk("s0_flush_occ", 256'(occupancy0), 256'(0));
    chk("s0_flush_in_ready", 256'(in_ready0), 256'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
